serial_accumulator: RTL

//  Receiving end of the adder_b serial stream: bit-serial two's-complement adder

---
 rtl/serial_accumulator.sv | 94 +++++++++
 1 files changed

// File: rtl/serial_accumulator.sv
// Bit-serial two's-complement adder with a recirculating accumulator tank.
// One digit per clk, LSB first; the sum re-enters the tank tail and returns one word later.
module serial_accumulator #(
  parameter int WORD_LEN = 72,
  parameter int CNT_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adder_b,
  input  logic                d0,
  input  logic                add_en,
  input  logic                clr_acc,
  output logic                acc_out,
  output logic [WORD_LEN-1:0] acc_word,
  output logic                acc_sign,
  output logic                ovf,
  output logic                sync_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_LEN - 1);

  logic [WORD_LEN-1:0] tank;
  logic                carry;
  logic [CNT_W-1:0]    cnt;
  logic                add_q, clr_q;

  logic [CNT_W-1:0]    cnt_eff, cnt_next;
  logic                add, clr, a, b, cin, sum, cout, last;

  assign acc_out = tank[0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_eff  = cnt;
    cnt_next = '0;
    add      = add_q;
    clr      = clr_q;
    a        = 1'b0;
    b        = 1'b0;
    cin      = 1'b0;
    sum      = 1'b0;
    cout     = 1'b0;
    last     = 1'b0;

    // d0 marks digit 0 and supplies this word's flags directly from the ports.
    if (d0) begin
      cnt_eff = '0;
      add     = add_en;
      clr     = clr_acc;
    end
    last     = (cnt_eff == LAST);
    cnt_next = last ? '0 : cnt_eff + 1'b1;

    a    = clr ? 1'b0 : acc_out;
    b    = add ? adder_b : 1'b0;
    cin  = (cnt_eff == '0) ? 1'b0 : carry;
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tank     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      add_q    <= 1'b0;
      clr_q    <= 1'b0;
      acc_word <= '0;
      acc_sign <= 1'b0;
      ovf      <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      tank  <= {sum, tank[WORD_LEN-1:1]};
      carry <= cout;
      cnt   <= cnt_next;

      if (d0) begin
        add_q <= add_en;
        clr_q <= clr_acc;
        // A registered count of zero means the previous interval was the last digit.
        if (cnt != '0) sync_err <= 1'b1;
        if (clr_acc)   ovf      <= 1'b0;
      end

      if (last) begin
        acc_word <= {sum, tank[WORD_LEN-1:1]};
        acc_sign <= sum;
        if (cin != cout) ovf <= 1'b1;
      end
    end
  end

endmodule
